// File: rtl/pipe_reg_if_id_if.sv
// Handshake bundle between the IF stage, the IF/ID skid buffer and the ID stage.
//   slave  : buffer side  (takes IF_* / flush / ID_ready, drives IF_ready / ID_* / count)
//   master : stage side   (drives IF_* / flush / ID_ready, observes the buffer outputs)
interface pipe_reg_if_id_if;
  logic [31:0] IF_pc_plus_4;
  logic [31:0] IF_inst;
  logic        IF_valid;
  logic        IF_ready;
  logic        flush;
  logic        ID_ready;
  logic        ID_valid;
  logic [31:0] ID_pc_plus_4;
  logic [31:0] ID_inst;
  logic [1:0]  count;

  modport slave (
    input  IF_pc_plus_4, IF_inst, IF_valid, flush, ID_ready,
    output IF_ready, ID_valid, ID_pc_plus_4, ID_inst, count
  );

  modport master (
    output IF_pc_plus_4, IF_inst, IF_valid, flush, ID_ready,
    input  IF_ready, ID_valid, ID_pc_plus_4, ID_inst, count
  );
endinterface

// File: rtl/pipe_reg_if_id.sv
// IF/ID pipeline register built as a 2-entry FIFO of {pc_plus_4, inst} records.
// Ports:
//   clock   - single rising-edge clock
//   resetn  - synchronous active-low reset (pointers and count only)
//   bus     - slave side of pipe_reg_if_id_if:
//             IF_valid/IF_ready/IF_pc_plus_4/IF_inst  fetch-side handshake
//             ID_valid/ID_ready/ID_pc_plus_4/ID_inst  decode-side handshake
//             flush                                   discard everything held and incoming
//             count                                   entries held (0..2)
// IF_ready depends only on registered state, so there is no combinational
// ready path from ID back to IF.
module pipe_reg_if_id #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic                  clock,
  input logic                  resetn,
  pipe_reg_if_id_if.slave      bus
);

  logic [63:0] mem_q [2];
  logic        rptr_q, rptr_d;
  logic        wptr_q, wptr_d;
  logic [1:0]  count_q, count_d;

  logic        if_ready;
  logic        id_valid;
  logic        push;
  logic        pop;
  logic [63:0] head;

  assign if_ready = (count_q != 2'd2);
  assign id_valid = (count_q != 2'd0);
  assign push     = bus.IF_valid & if_ready;
  assign pop      = id_valid & bus.ID_ready;
  assign head     = mem_q[rptr_q];

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (bus.flush) begin
      rptr_d  = 1'b0;
      wptr_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the output mux below hides stale entries.
  always_ff @(posedge clock) begin
    if (push && !bus.flush) begin
      mem_q[wptr_q] <= {bus.IF_pc_plus_4, bus.IF_inst};
    end
  end

  assign bus.IF_ready     = if_ready;
  assign bus.ID_valid     = id_valid;
  assign bus.ID_pc_plus_4 = id_valid ? head[63:32] : 32'h0;
  assign bus.ID_inst      = id_valid ? head[31:0]  : NOP_INST;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_pipe_reg_if_id.sv
module tb_pipe_reg_if_id;
  logic clock;
  logic resetn;
  pipe_reg_if_id_if bus ();

  pipe_reg_if_id #(.NOP_INST(32'h0000_0000)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference: an ordered queue of accepted records, capacity two.
  logic [63:0] mq[$];
  bit          model_on = 1'b0;

  localparam logic [31:0] InstA = 32'hAAAA_0001;
  localparam logic [31:0] InstB = 32'hBBBB_0002;
  localparam logic [31:0] InstC = 32'hCCCC_0003;
  localparam logic [31:0] InstD = 32'hDDDD_0004;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model update on the edge, from the inputs that were stable before it.
  always @(posedge clock) begin
    bit acc, take;
    acc  = bus.IF_valid && (mq.size() < 2);
    take = bus.ID_ready && (mq.size() > 0);
    if (!resetn) begin
      mq.delete();
      model_on = 1'b1;
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      if (take) void'(mq.pop_front());
      if (acc)  mq.push_back({bus.IF_pc_plus_4, bus.IF_inst});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_on) begin
      chk("count", {30'd0, bus.count}, mq.size());
      chk("ID_valid", {31'd0, bus.ID_valid}, {31'd0, mq.size() != 0});
      chk("IF_ready", {31'd0, bus.IF_ready}, {31'd0, mq.size() < 2});
      chk("ID_inst", bus.ID_inst, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
      chk("ID_pc_plus_4", bus.ID_pc_plus_4, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
    end
  end

  // Apply one cycle of inputs, then return 1 time unit after the next edge.
  task automatic cyc(input logic ifv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic fl, input logic idr, input logic rn);
    bus.IF_valid     = ifv;
    bus.IF_pc_plus_4 = pc;
    bus.IF_inst      = inst;
    bus.flush        = fl;
    bus.ID_ready     = idr;
    resetn           = rn;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.IF_valid = 1'b0;
    bus.IF_pc_plus_4 = '0;
    bus.IF_inst = '0;
    bus.flush = 1'b0;
    bus.ID_ready = 1'b0;
    resetn = 1'b0;

    // Empty outputs after reset, three idle cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("empty_valid", {31'd0, bus.ID_valid}, 32'd0);
      chk("empty_inst", bus.ID_inst, 32'h0);
      chk("empty_pc", bus.ID_pc_plus_4, 32'h0);
      chk("empty_ifready", {31'd0, bus.IF_ready}, 32'd1);
    end

    // Streaming with ID always ready.
    cyc(1'b1, 32'd4, InstA, 1'b0, 1'b1, 1'b1);
    chk("stream_A", bus.ID_inst, InstA);
    chk("stream_pc4", bus.ID_pc_plus_4, 32'd4);
    cyc(1'b1, 32'd8, InstB, 1'b0, 1'b1, 1'b1);
    chk("stream_B", bus.ID_inst, InstB);
    chk("stream_cnt", {30'd0, bus.count}, 32'd1);
    cyc(1'b1, 32'd12, InstC, 1'b0, 1'b1, 1'b1);
    chk("stream_C", bus.ID_inst, InstC);
    chk("stream_pc12", bus.ID_pc_plus_4, 32'd12);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("stream_drain", {30'd0, bus.count}, 32'd0);

    // Stall fill, third offer refused, then drain in order.
    cyc(1'b1, 32'd4, InstA, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'd8, InstB, 1'b0, 1'b0, 1'b1);
    chk("fill_cnt", {30'd0, bus.count}, 32'd2);
    chk("fill_ifready", {31'd0, bus.IF_ready}, 32'd0);
    chk("fill_head", bus.ID_inst, InstA);
    chk("model_fill", mq.size(), 32'd2);
    cyc(1'b1, 32'd12, InstC, 1'b0, 1'b0, 1'b1);
    chk("fill_refuse", bus.ID_inst, InstA);
    cyc(1'b1, 32'd12, InstC, 1'b0, 1'b1, 1'b1);
    chk("fill_B", bus.ID_inst, InstB);
    chk("fill_cnt1", {30'd0, bus.count}, 32'd1);
    chk("fill_ifready1", {31'd0, bus.IF_ready}, 32'd1);
    cyc(1'b1, 32'd12, InstC, 1'b0, 1'b1, 1'b1);
    chk("fill_C", bus.ID_inst, InstC);
    chk("fill_Cpc", bus.ID_pc_plus_4, 32'd12);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Flush with a full buffer, an incoming push and a pop.
    cyc(1'b1, 32'd4, InstA, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'd8, InstB, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'd12, InstC, 1'b1, 1'b1, 1'b1);
    chk("flush_cnt", {30'd0, bus.count}, 32'd0);
    chk("flush_valid", {31'd0, bus.ID_valid}, 32'd0);
    chk("flush_inst", bus.ID_inst, 32'h0);
    chk("model_flush", mq.size(), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("flush_noC", {30'd0, bus.count}, 32'd0);

    // Flush during a stall still empties the buffer.
    cyc(1'b1, 32'd4, InstA, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("flush_stall", {30'd0, bus.count}, 32'd0);

    // Wrap: alternate count 1 -> 2 -> 1 for six cycles.
    cyc(1'b1, 32'd100, 32'h1000_0000, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 32'd100 + 32'(i) * 4, 32'h1000_0000 + 32'(i), 1'b0, 1'(i % 2 == 0), 1'b1);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation overrides everything.
    cyc(1'b1, 32'd4, InstA, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'd8, InstB, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'd12, InstC, 1'b1, 1'b1, 1'b0);
    chk("rst_cnt", {30'd0, bus.count}, 32'd0);
    chk("rst_ifready", {31'd0, bus.IF_ready}, 32'd1);
    chk("rst_valid", {31'd0, bus.ID_valid}, 32'd0);
    chk("rst_inst", bus.ID_inst, 32'h0);
    cyc(1'b1, 32'd16, InstD, 1'b0, 1'b0, 1'b1);
    chk("rst_D", bus.ID_inst, InstD);
    chk("rst_Dpc", bus.ID_pc_plus_4, 32'd16);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 63) != 0));
    end

    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_reg_if_id.md
PIPE_REG_IF_ID -- requirements
Module: pipe_reg_if_id

Interface
REQ-001 Parameter: NOP_INST, 32'h0000_0000, instruction word presented on ID_inst when no valid entry is held (sll $0,$0,0).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset is synchronous and active-low; sampled on the rising edge of clock.
REQ-004 IF_pc_plus_4  input  32  PC+4 of the instruction being fetched.
REQ-005 IF_inst  input  32  instruction word from instruction ROM.
REQ-006 IF_valid  input  1  IF offers {IF_pc_plus_4, IF_inst} this cycle.
REQ-007 IF_ready  output  1  buffer accepts an IF entry this cycle; high when fewer than 2 entries held.
REQ-008 flush  input  1  control transfer resolved (pcsource != 0); discard all held and incoming entries.
REQ-009 ID_ready  input  1  ID consumes the head entry this cycle (low = load-use or other stall).
REQ-010 ID_valid  output  1  head entry valid.
REQ-011 ID_pc_plus_4  output  32  PC+4 of head entry.
REQ-012 ID_inst  output  32  instruction of head entry.
REQ-013 count  output  2  entries held: 0, 1 or 2.

Function
REQ-014 Storage: 2-entry FIFO of 64-bit records {pc_plus_4, inst}; 1-bit read pointer, 1-bit write pointer, 2-bit count.
REQ-015 push = IF_valid & IF_ready; pop = ID_valid & ID_ready; both evaluated before the clock edge.
REQ-016 IF_ready = (count != 2); depends only on registered state, never on ID_ready (no combinational ready path).
REQ-017 ID_valid = (count != 0); ID_pc_plus_4/ID_inst driven from the entry at the read pointer.
REQ-018 count = 0: ID_inst = NOP_INST and ID_pc_plus_4 = 32'h0; stale storage never visible.
REQ-019 push only: write at wptr, wptr toggles, count+1.
REQ-020 pop only: rptr toggles, count-1.
REQ-021 push and pop same cycle (count 1): write at wptr, both pointers toggle, count unchanged; the new entry appears at the head next cycle.
REQ-022 push and pop same cycle with count 0: impossible (pop requires ID_valid); count becomes 1 and the entry appears next cycle (1-cycle latency IF to ID).
REQ-023 count = 2: IF_ready = 0, push blocked; pop frees one slot, IF_ready high next cycle.
REQ-024 Pointer wrap: pointers are 1 bit and wrap 1 -> 0 naturally; ordering preserved across any wrap.
REQ-025 flush: next edge count = 0, rptr = wptr = 0; same-cycle push and pop discarded; flush has priority over push and pop.
REQ-026 flush with ID_ready low (stall): flush still wins; buffer empty next cycle.
REQ-027 Data order: entries leave in exactly the order accepted; no duplication or loss except by flush/reset.
REQ-028 Storage contents need not be reset; only pointers and count are.

Reset
REQ-029 resetn low at a rising edge: count = 0, rptr = 0, wptr = 0; ID_valid = 0, IF_ready = 1, ID_inst = NOP_INST, ID_pc_plus_4 = 0 from the following cycle.
REQ-030 Reset overrides flush, push and pop in the same cycle; reset mid-operation discards all held entries.
REQ-031 Output values during the reset cycle itself: don't care; only the post-edge state is defined.

Verification
REQ-032 Streaming: ID_ready=1, push pc+4=4,8,12 with insts A,B,C on consecutive cycles -> ID shows A/4, B/8, C/12 one cycle later each, count stays 1.
REQ-033 Stall fill: ID_ready=0, push A/4, B/8 -> count=2, IF_ready=0, head A/4; third offer C/12 not accepted; ID_ready=1 -> A then B out, then C accepted on the cycle IF_ready returns.
REQ-034 Flush: count=2 (A,B), flush=1 with IF_valid=1 (C) and ID_ready=1 -> next cycle count=0, ID_valid=0, ID_inst=0; C never appears.
REQ-035 Wrap: 6 push/pop cycles alternating count 1->2->1 -> output sequence equals input sequence, no loss.
REQ-036 Reset mid-op: count=2, resetn=0 for one edge -> count=0, IF_ready=1, ID_valid=0, ID_inst=NOP_INST; next push D/16 appears as head one cycle later.
REQ-037 Empty outputs: after reset, no pushes for 3 cycles -> ID_valid=0, ID_inst=32'h0, ID_pc_plus_4=32'h0 every cycle.
